// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit
//  Purpose  : Condition/flags stage that sits directly after the ALU.
//             - Holds the architectural NZCV flags.
//             - Checks each instruction's 4-bit condition field against the
//               stored flags.
//             - Gates the branch, register-write and memory-write controls.
//             - Updates the flags from ALUFlags.
//             - Keeps saturating counters of executed and skipped live
//               instructions.
//  Ports    : clk, reset (sync, active-high)
//             en, flush, valid_in          - pipeline slot control
//             Cond[3:0], ALUFlags[3:0]     - condition field, {N,Z,C,V} from ALU
//             FlagW[1:0]                   - [1] writes N,Z ; [0] writes C,V
//             PCS, RegW, MemW, NoWrite     - raw control inputs
//             PCSrc, RegWrite, MemWrite    - gated controls (combinational)
//             CondEx                       - live instruction passed its condition
//             Flags[3:0]                   - stored {N,Z,C,V}
//             exec_cnt, skip_cnt [CNT_W]   - saturating instruction counters
//  Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       flags_reg;
   logic [CNT_W-1:0] exec_reg;
   logic [CNT_W-1:0] skip_reg;

   logic             live;
   logic             cond_pass;
   logic             cond_ex;
   logic             flag_n, flag_z, flag_c, flag_v;

   assign flag_n = flags_reg[3];
   assign flag_z = flags_reg[2];
   assign flag_c = flags_reg[1];
   assign flag_v = flags_reg[0];

   // The condition is decoded against the stored flags, so a flag-setting
   // instruction only affects the instructions that follow it.
   always_comb begin
      cond_pass = 1'b0;
      case (Cond)
         4'h0:    cond_pass = flag_z;
         4'h1:    cond_pass = ~flag_z;
         4'h2:    cond_pass = flag_c;
         4'h3:    cond_pass = ~flag_c;
         4'h4:    cond_pass = flag_n;
         4'h5:    cond_pass = ~flag_n;
         4'h6:    cond_pass = flag_v;
         4'h7:    cond_pass = ~flag_v;
         4'h8:    cond_pass = flag_c & ~flag_z;
         4'h9:    cond_pass = ~flag_c | flag_z;
         4'hA:    cond_pass = (flag_n == flag_v);
         4'hB:    cond_pass = (flag_n != flag_v);
         4'hC:    cond_pass = ~flag_z & (flag_n == flag_v);
         4'hD:    cond_pass = flag_z | (flag_n != flag_v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;   // reserved encoding never executes
      endcase
   end

   // Reset is folded in here so that every gated output and both counter
   // enables are quiet during the reset cycle.
   assign live    = valid_in & en & ~flush & ~reset;
   assign cond_ex = live & cond_pass;

   assign CondEx   = cond_ex;
   assign PCSrc    = PCS & cond_ex;
   assign RegWrite = RegW & cond_ex & ~NoWrite;
   assign MemWrite = MemW & cond_ex;

   // The state outputs also read zero while reset is asserted.
   assign Flags    = reset ? 4'b0000 : flags_reg;
   assign exec_cnt = reset ? {CNT_W{1'b0}} : exec_reg;
   assign skip_cnt = reset ? {CNT_W{1'b0}} : skip_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_reg <= 4'b0000;
         exec_reg  <= {CNT_W{1'b0}};
         skip_reg  <= {CNT_W{1'b0}};
      end else begin
         if (cond_ex) begin
            // The two flag halves are written independently.
            if (FlagW[1]) flags_reg[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_reg[1:0] <= ALUFlags[1:0];
            if (!(&exec_reg)) exec_reg <= exec_reg + CNT_ONE;
         end
         if (live && !cond_pass && !(&skip_reg)) begin
            skip_reg <= skip_reg + CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_unit
//  Purpose  : Self-checking bench for cond_unit (built with CNT_W=4).
//             Each applied vector pushes its expected outputs to a
//             scoreboard queue. The entry is popped and compared when the
//             DUT outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, en, flush, valid_in;
   logic [3:0]       Cond, ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, RegW, MemW, NoWrite;
   logic             PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] exec_cnt, skip_cnt;

   always #5 clk = ~clk;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
      .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
      .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
   );

   typedef struct {
      logic             ce, pc, rw, mw;
      logic [3:0]       fl;
      logic [CNT_W-1:0] ex, sk;
   } exp_t;

   exp_t sb[$];

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state
   logic [3:0]       m_flags = 4'b0000;
   logic [CNT_W-1:0] m_exec  = '0;
   logic [CNT_W-1:0] m_skip  = '0;

   // Last observed outputs, for the directed spot checks
   logic             o_ce, o_pc, o_rw, o_mw;
   logic [3:0]       o_fl;
   logic [CNT_W-1:0] o_ex, o_sk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pass_f(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;          4'h1: return !z;
         4'h2: return cy;         4'h3: return !cy;
         4'h4: return n;          4'h5: return !n;
         4'h6: return v;          4'h7: return !v;
         4'h8: return cy && !z;   4'h9: return !cy || z;
         4'hA: return n == v;     4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply(input string tag, input logic rst, input logic e, input logic fl,
                        input logic v, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw);
      exp_t x, got;
      logic lv, ce;
      @(negedge clk);
      reset = rst; en = e; flush = fl; valid_in = v; Cond = c; ALUFlags = af;
      FlagW = fw; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
      lv = v && e && !fl && !rst;
      ce = lv && pass_f(c, m_flags);
      x.ce = ce;
      x.pc = pcs && ce;
      x.rw = rw && ce && !nw;
      x.mw = mw && ce;
      x.fl = rst ? 4'b0 : m_flags;
      x.ex = rst ? '0 : m_exec;
      x.sk = rst ? '0 : m_skip;
      sb.push_back(x);
      #2;
      got = sb.pop_front();
      o_ce = CondEx; o_pc = PCSrc; o_rw = RegWrite; o_mw = MemWrite;
      o_fl = Flags;  o_ex = exec_cnt; o_sk = skip_cnt;
      chk({tag, ".CondEx"},   32'(o_ce), 32'(got.ce));
      chk({tag, ".PCSrc"},    32'(o_pc), 32'(got.pc));
      chk({tag, ".RegWrite"}, 32'(o_rw), 32'(got.rw));
      chk({tag, ".MemWrite"}, 32'(o_mw), 32'(got.mw));
      chk({tag, ".Flags"},    32'(o_fl), 32'(got.fl));
      chk({tag, ".exec_cnt"}, 32'(o_ex), 32'(got.ex));
      chk({tag, ".skip_cnt"}, 32'(o_sk), 32'(got.sk));
      // Advance the reference state to what the clock edge will produce
      if (rst) begin
         m_flags = 4'b0; m_exec = '0; m_skip = '0;
      end else begin
         if (ce) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
            if (m_exec != '1) m_exec = m_exec + 1'b1;
         end
         if (lv && !ce && m_skip != '1) m_skip = m_skip + 1'b1;
      end
   endtask

   // Idle (bubble) cycle: shows the state left by the previous vector.
   task automatic idle(input string tag);
      apply(tag, 0, 1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; en = 0; flush = 0; valid_in = 0; Cond = 0; ALUFlags = 0;
      FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;

      // 1: reset, with an AL register write presented during the reset cycle
      apply("rst", 1, 1, 0, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
      chk("rst_regwrite", 32'(o_rw), 32'h0);
      idle("rst_idle");
      chk("rst_flags", 32'(o_fl), 32'h0);
      chk("rst_exec",  32'(o_ex), 32'h0);

      // 2: SUBS sets Z, then BEQ is taken
      apply("subs", 0, 1, 0, 1, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 0);
      apply("beq",  0, 1, 0, 1, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0);
      chk("beq_flags", 32'(o_fl), 32'h6);
      chk("beq_pcsrc", 32'(o_pc), 32'h1);
      idle("beq_idle");
      chk("beq_exec", 32'(o_ex), 32'h2);

      // 3: partial flag write (only N,Z), then HI fails
      apply("set1010", 0, 1, 0, 1, 4'hE, 4'b1010, 2'b11, 0, 0, 0, 0);
      apply("part",    0, 1, 0, 1, 4'hE, 4'b0101, 2'b10, 0, 0, 0, 0);
      apply("hi",      0, 1, 0, 1, 4'h8, 4'b0000, 2'b00, 0, 1, 0, 0);
      chk("part_flags", 32'(o_fl), 32'h6);
      chk("hi_condex",  32'(o_ce), 32'h0);
      idle("hi_idle");
      chk("hi_skip", 32'(o_sk), 32'h1);

      // 4: CMP suppresses RegWrite; the reserved condition never executes
      apply("cmp",  0, 1, 0, 1, 4'hE, 4'b1001, 2'b11, 0, 1, 0, 1);
      chk("cmp_regwrite", 32'(o_rw), 32'h0);
      chk("cmp_condex",   32'(o_ce), 32'h1);
      apply("rsvd", 0, 1, 0, 1, 4'hF, 4'b0000, 2'b00, 0, 0, 1, 0);
      chk("cmp_flags",     32'(o_fl), 32'h9);
      chk("rsvd_memwrite", 32'(o_mw), 32'h0);

      // 5: stall, then flush (flush overrides valid_in)
      apply("stall", 0, 0, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
      apply("flush", 0, 1, 1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
      chk("flush_condex", 32'(o_ce), 32'h0);
      idle("sf_idle");
      chk("sf_flags", 32'(o_fl), 32'h9);

      // Every condition code, under random flags and controls
      for (int i = 0; i < 160; i++) begin
         apply("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
               4'(i % 16), 4'($urandom), 2'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Reset in the middle of a flag-writing instruction drops the update
      apply("rst_mid", 1, 1, 0, 1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
      idle("rst_mid_idle");
      chk("rst_mid_flags", 32'(o_fl), 32'h0);

      // 6: saturation of both counters (2^CNT_W + 3 instructions each)
      for (int i = 0; i < (1 << CNT_W) + 3; i++)
         apply("sat_ex", 0, 1, 0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < (1 << CNT_W) + 3; i++)
         apply("sat_sk", 0, 1, 0, 1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
      idle("sat_idle");
      chk("sat_exec", 32'(o_ex), 32'hF);
      chk("sat_skip", 32'(o_sk), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
